// File: rtl/tc0480scp_rom_sched.sv
// Tile-row ROM fetch scheduler for the TC0480SCP background layers.
// Requesters raise toggle requests; grants are issued round-robin, blank
// tiles are answered locally with zero data, and all other tiles are fetched
// through a single toggle-handshake ROM port with one transaction in flight.
module tc0480scp_rom_sched #(
    parameter int N_REQ  = 4,
    parameter int ADDR_W = 23,
    parameter int DATA_W = 64
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [N_REQ-1:0]           req,
    output logic [N_REQ-1:0]           ack,
    input  logic [16*N_REQ-1:0]        code,
    input  logic [4*N_REQ-1:0]         row,
    input  logic [N_REQ-1:0]           flipy,
    output logic [N_REQ-1:0]           load,
    output logic [DATA_W-1:0]          load_data,
    output logic [ADDR_W-1:0]          rom_address,
    output logic                       rom_req,
    input  logic                       rom_ack,
    input  logic [DATA_W-1:0]          rom_data,
    output logic                       busy,
    output logic [$clog2(N_REQ)-1:0]   grant_idx
);

    localparam int IDX_W  = $clog2(N_REQ);
    // Natural address width: 16-bit code, 4-bit row, 8 words per... 3 low zero bits.
    localparam int FULL_W = 23;

    typedef enum logic {
        S_IDLE,
        S_WAIT_ACK
    } state_t;

    state_t              state_reg;
    logic [N_REQ-1:0]    ack_reg;
    logic [N_REQ-1:0]    load_reg;
    logic [DATA_W-1:0]   load_data_reg;
    logic [ADDR_W-1:0]   rom_address_reg;
    logic                rom_req_reg;
    logic [IDX_W-1:0]    grant_idx_reg;

    logic [15:0]         code_arr  [N_REQ];
    logic [3:0]          row_arr   [N_REQ];
    logic                flipy_arr [N_REQ];

    logic [N_REQ-1:0]    pending;
    logic                sel_found;
    logic [IDX_W-1:0]    sel_idx;
    logic [IDX_W:0]      scan_sum;
    logic [15:0]         sel_code;
    logic [3:0]          sel_row;
    logic                sel_flipy;
    logic                sel_blank;
    logic [FULL_W-1:0]   addr_full;

    // Unpack the flat per-layer attribute buses into indexable arrays.
    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
            assign code_arr[gi]  = code[16*gi +: 16];
            assign row_arr[gi]   = row[4*gi +: 4];
            assign flipy_arr[gi] = flipy[gi];
        end
    endgenerate

    assign pending = req ^ ack_reg;

    // Round-robin pick: first pending layer after the last granted one.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        scan_sum  = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            scan_sum = {1'b0, grant_idx_reg} + (IDX_W+1)'(k);
            if (scan_sum >= (IDX_W+1)'(N_REQ)) begin
                scan_sum = scan_sum - (IDX_W+1)'(N_REQ);
            end
            if (!sel_found && pending[scan_sum[IDX_W-1:0]]) begin
                sel_found = 1'b1;
                sel_idx   = scan_sum[IDX_W-1:0];
            end
        end
    end

    // Attributes of the selected layer and the ROM word address they map to.
    always_comb begin
        sel_code  = code_arr[sel_idx];
        sel_row   = row_arr[sel_idx];
        sel_flipy = flipy_arr[sel_idx];
        sel_blank = (sel_code[14:0] == 15'd0);
        addr_full = {sel_code, sel_row ^ {4{sel_flipy}}, 3'b000};
    end

    // Scheduler state machine: grant, short-circuit blanks, await ROM completion.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg       <= S_IDLE;
            ack_reg         <= '0;
            load_reg        <= '0;
            load_data_reg   <= '0;
            rom_address_reg <= '0;
            rom_req_reg     <= 1'b0;
            grant_idx_reg   <= IDX_W'(N_REQ - 1);
        end else begin
            load_reg <= '0;
            case (state_reg)
                S_IDLE: begin
                    if (sel_found) begin
                        grant_idx_reg <= sel_idx;
                        if (sel_blank) begin
                            load_data_reg     <= '0;
                            load_reg[sel_idx] <= 1'b1;
                            ack_reg[sel_idx]  <= ~ack_reg[sel_idx];
                        end else begin
                            rom_address_reg <= ADDR_W'(addr_full);
                            rom_req_reg     <= ~rom_req_reg;
                            state_reg       <= S_WAIT_ACK;
                        end
                    end
                end
                S_WAIT_ACK: begin
                    // Completion is only looked for from the cycle after issue.
                    if (rom_ack == rom_req_reg) begin
                        load_data_reg           <= rom_data;
                        load_reg[grant_idx_reg] <= 1'b1;
                        ack_reg[grant_idx_reg]  <= ~ack_reg[grant_idx_reg];
                        state_reg               <= S_IDLE;
                    end
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

    assign ack         = ack_reg;
    assign load        = load_reg;
    assign load_data   = load_data_reg;
    assign rom_address = rom_address_reg;
    assign rom_req     = rom_req_reg;
    assign busy        = (state_reg == S_WAIT_ACK);
    assign grant_idx   = grant_idx_reg;

endmodule
